fetch_bpred: RTL and testbench
==============================

Name: fetch_bpred

Overview:
- Parametrised successor to the IF stage with IF/ID latch.
- Replaces static "always taken" prediction with a direct-mapped branch target buffer (BTB) of saturating counters, updated from the EX-stage branch resolution.
- Sits between the PC unit/icache and decode. It supplies the predicted next-PC to the PC unit and holds the IF/ID latch fields.

Parameters:
BTB_ENTRIES, 16, number of BTB entries; power of two, >= 2; IDX_W = log2(BTB_ENTRIES)
CTR_BITS, 2, saturating counter width, >= 1
WORD_W, 32, instruction/address width (fixed ISA width; kept for typing)

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
ihit  in  1  icache returned valid instruction this cycle
imemload  in  32  fetched instruction
pc  in  32  PC of the instruction on imemload
stall  in  1  hazard unit stall; hold IF/ID latch
flush  in  1  hazard unit flush; clear IF/ID latch
upd_en  in  1  EX stage resolved a conditional branch this cycle
upd_pc  in  32  PC of the resolved branch
upd_taken  in  1  actual outcome
upd_target  in  32  actual taken target
pred_taken  out  1  redirect fetch this cycle (combinational)
pred_target  out  32  redirect address (combinational)
instr_r  out  32  IF/ID instruction
npc_r  out  32  IF/ID pc+4
pred_taken_r  out  1  IF/ID prediction, carried to EX for mispredict check
pred_target_r  out  32  IF/ID predicted target
mispred_cnt  out  32  count of resolved mispredictions

Behaviour:
- npc = pc + 4, 32-bit wrap.
- BTB lookup (combinational):
  - idx = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
  - Entry fields: valid, tag, target[31:0], ctr[CTR_BITS-1:0].
  - btb_hit = valid[idx] && tag[idx] == tag.
- Decode (only when ihit=1; otherwise pred_taken=0 and pred_target=0):
  - J/JAL: pred_taken=1; pred_target={npc[31:28], imm26, 2'b00}. BTB not consulted.
  - BEQ/BNE:
    - On btb_hit: pred_taken = ctr[idx][CTR_BITS-1]; pred_target = BTB target.
    - On miss: pred_taken=0, pred_target=0.
  - All other opcodes: pred_taken=0, pred_target=0.
- BTB update (upd_en=1), sampled on posedge CLK, index and tag taken from upd_pc:
  - Hit: ctr saturating +1 if taken, -1 if not taken, clamped to [0, 2^CTR_BITS-1]. Target is written only when taken.
  - Miss: allocate. Set valid=1, tag, target=upd_target. ctr = 2^(CTR_BITS-1) if taken (weakly taken), else 2^(CTR_BITS-1)-1 (weakly not-taken).
  - CTR_BITS=1: allocate ctr=upd_taken.
- Lookup and update to the same index in the same cycle: lookup sees pre-update contents. There is no bypass.
- Misprediction counting:
  - mispred = upd_en && (upd_taken != pre-update BTB prediction for upd_pc).
  - Pre-update prediction is 0 on BTB miss.
  - mispred_cnt increments by 1 on each mispred and wraps at 2^32.
- IF/ID latch priority: reset > flush > (ihit && !stall) load > hold.
  - Load: instr_r=imemload, npc_r=npc, pred_taken_r=pred_taken, pred_target_r=pred_target.
  - Flush: all latch fields 0, which is a bubble (instr_r=0 is sll $0 = nop).
  - Flush wins over a simultaneous ihit or stall.
  - Hold: all latch fields unchanged; this covers stall=1 or ihit=0.
- BTB update is independent of stall/flush and is still applied during both.
- Reset (async on nRST low):
  - All valid bits, ctr and target are 0.
  - instr_r, npc_r, pred_taken_r, pred_target_r are 0.
  - mispred_cnt is 0.
  - Reset asserted mid-operation discards any pending update that cycle.

Optional Feature:
FETCH_BTFN_EN
- Defined: on a BTB miss for BEQ/BNE, predict backward-taken/forward-not-taken.
  - Compute off = sign-extended imm16 << 2.
  - If imm16[15]=1: pred_taken=1 and pred_target = npc + off.
  - Otherwise pred_taken=0.
  - The pre-update prediction used for mispred_cnt follows the same rule on a miss.
- Undefined: BTB miss predicts not-taken, as described above.

Test Plan:
- Reset, then ihit=1, pc=0x0000_0040, imemload=J 0x0000100 -> pred_taken=1, pred_target=0x0000_0400; next edge npc_r=0x44, pred_taken_r=1.
- BEQ at pc=0x80 with cold BTB -> pred_taken=0. Apply upd_en with taken=1, target=0x60 -> mispred_cnt=1. Refetch -> pred_taken=1, pred_target=0x60 (ctr=2).
- Same BEQ: two more not-taken updates -> ctr 2->1->0 and the second shows pred_taken=0; a further not-taken keeps ctr=0 (saturates). Then three taken -> ctr 1,2,3; a fourth stays at 3.
- Aliasing: pc=0x80 and pc=0xC0 with BTB_ENTRIES=16 (same idx, different tag). Update 0xC0 -> fetch of 0x80 misses -> pred_taken=0.
- Latch control: ihit=1 with flush=1 and stall=1 together -> instr_r=0. ihit=1 with stall=1 -> latch holds the previous value. ihit=0 -> latch holds.
- With FETCH_BTFN_EN defined: cold BTB, BNE at pc=0x100 with imm=0xFFFE -> pred_taken=1, pred_target=0xFC. Without the macro -> pred_taken=0.

Source files
------------

// File: rtl/fetch_bpred.sv
// fetch_bpred -- IF stage with IF/ID latch and a direct-mapped BTB predictor.
//
// Looks up the fetched PC in a branch target buffer of saturating counters
// and hands a predicted next-PC back to the PC unit. The BTB is trained from
// the EX-stage branch resolution. The IF/ID latch fields are registered
// here as well.
//
// Optional feature macro: FETCH_BTFN_EN
//   When defined, a BTB miss on BEQ/BNE predicts backward-taken /
//   forward-not-taken instead of not-taken.
//
// Ports:
//   CLK, nRST      clock; asynchronous active-low reset
//   ihit           icache delivered a valid instruction this cycle
//   imemload, pc   fetched instruction and its PC
//   stall, flush   hazard unit controls for the IF/ID latch
//   upd_*          EX-stage resolution of a conditional branch
//   pred_taken     redirect fetch this cycle (combinational)
//   pred_target    redirect address (combinational)
//   instr_r, npc_r, pred_taken_r, pred_target_r   IF/ID latch fields
//   mispred_cnt    running count of resolved mispredictions (wraps)

module fetch_bpred #(
   parameter int unsigned BTB_ENTRIES = 16,
   parameter int unsigned CTR_BITS    = 2,
   parameter int unsigned WORD_W      = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              ihit,
   input  logic [WORD_W-1:0] imemload,
   input  logic [WORD_W-1:0] pc,
   input  logic              stall,
   input  logic              flush,
   input  logic              upd_en,
   input  logic [WORD_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [WORD_W-1:0] upd_target,
   output logic              pred_taken,
   output logic [WORD_W-1:0] pred_target,
   output logic [WORD_W-1:0] instr_r,
   output logic [WORD_W-1:0] npc_r,
   output logic              pred_taken_r,
   output logic [WORD_W-1:0] pred_target_r,
   output logic [WORD_W-1:0] mispred_cnt
);

   localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
   localparam int unsigned TAG_W = WORD_W - IDX_W - 2;

   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_JAL = 6'h03;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_BNE = 6'h05;

   localparam logic [CTR_BITS-1:0] CTR_ONE     = CTR_BITS'(1);
   localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
   // Weakly taken = MSB set, rest clear; weakly not-taken is one below.
   // With CTR_BITS=1 these collapse to 1 and 0.
   localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_ONE << (CTR_BITS - 1);
   localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_ONE;

   // BTB storage
   logic                btb_valid  [BTB_ENTRIES];
   logic [TAG_W-1:0]    btb_tag    [BTB_ENTRIES];
   logic [WORD_W-1:0]   btb_target [BTB_ENTRIES];
   logic [CTR_BITS-1:0] btb_ctr    [BTB_ENTRIES];

   // Fetch-side lookup
   logic [IDX_W-1:0]  f_idx;
   logic [TAG_W-1:0]  f_tag;
   logic              f_hit;
   logic [WORD_W-1:0] npc;
   logic [5:0]        opcode;

   assign f_idx  = pc[IDX_W+1:2];
   assign f_tag  = pc[WORD_W-1:IDX_W+2];
   assign f_hit  = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
   assign npc    = pc + 32'd4;
   assign opcode = imemload[31:26];

`ifdef FETCH_BTFN_EN
   logic [WORD_W-1:0] br_off;
   assign br_off = {{14{imemload[15]}}, imemload[15:0], 2'b00};
`endif

   always_comb begin
      pred_taken  = 1'b0;
      pred_target = '0;
      if (ihit) begin
         case (opcode)
            OP_J, OP_JAL: begin
               pred_taken  = 1'b1;
               pred_target = {npc[31:28], imemload[25:0], 2'b00};
            end
            OP_BEQ, OP_BNE: begin
               if (f_hit) begin
                  pred_taken  = btb_ctr[f_idx][CTR_BITS-1];
                  pred_target = btb_target[f_idx];
               end
`ifdef FETCH_BTFN_EN
               else if (imemload[15]) begin
                  pred_taken  = 1'b1;
                  pred_target = npc + br_off;
               end
`endif
            end
            default: begin
               pred_taken  = 1'b0;
               pred_target = '0;
            end
         endcase
      end
   end

   // Update-side lookup (pre-update contents)
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_hit;
   logic             u_pred;
   logic             mispred;

   assign u_idx = upd_pc[IDX_W+1:2];
   assign u_tag = upd_pc[WORD_W-1:IDX_W+2];
   assign u_hit = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);

`ifdef FETCH_BTFN_EN
   // The resolved branch's immediate is not available here, so its
   // direction is recovered from the resolved target relative to pc+4.
   logic [WORD_W-1:0] u_diff;
   assign u_diff = upd_target - (upd_pc + 32'd4);
   assign u_pred = u_hit ? btb_ctr[u_idx][CTR_BITS-1] : u_diff[WORD_W-1];
`else
   assign u_pred = u_hit ? btb_ctr[u_idx][CTR_BITS-1] : 1'b0;
`endif

   assign mispred = upd_en && (upd_taken != u_pred);

   // BTB training; runs regardless of stall/flush
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         btb_valid  <= '{default: 1'b0};
         btb_tag    <= '{default: '0};
         btb_target <= '{default: '0};
         btb_ctr    <= '{default: '0};
      end else if (upd_en) begin
         if (u_hit) begin
            if (upd_taken) begin
               btb_target[u_idx] <= upd_target;
               if (btb_ctr[u_idx] != CTR_MAX)
                  btb_ctr[u_idx] <= btb_ctr[u_idx] + CTR_ONE;
            end else if (btb_ctr[u_idx] != '0) begin
               btb_ctr[u_idx] <= btb_ctr[u_idx] - CTR_ONE;
            end
         end else begin
            btb_valid[u_idx]  <= 1'b1;
            btb_tag[u_idx]    <= u_tag;
            btb_target[u_idx] <= upd_target;
            btb_ctr[u_idx]    <= upd_taken ? CTR_WEAK_T : CTR_WEAK_NT;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         mispred_cnt <= '0;
      else if (mispred)
         mispred_cnt <= mispred_cnt + 32'd1;
   end

   // IF/ID latch: flush beats load, load needs ihit && !stall
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         instr_r       <= '0;
         npc_r         <= '0;
         pred_taken_r  <= 1'b0;
         pred_target_r <= '0;
      end else if (flush) begin
         instr_r       <= '0;
         npc_r         <= '0;
         pred_taken_r  <= 1'b0;
         pred_target_r <= '0;
      end else if (ihit && !stall) begin
         instr_r       <= imemload;
         npc_r         <= npc;
         pred_taken_r  <= pred_taken;
         pred_target_r <= pred_target;
      end
   end

   // Word-offset bits never take part in indexing or tagging
   logic unused_bits;
   assign unused_bits = &{1'b0, pc[1:0], upd_pc[1:0]};

endmodule

// File: tb/tb_fetch_bpred.sv
module tb_fetch_bpred;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        ihit, stall, flush;
   logic [31:0] imemload, pc;
   logic        upd_en, upd_taken;
   logic [31:0] upd_pc, upd_target;
   logic        pred_taken, pred_taken_r;
   logic [31:0] pred_target, instr_r, npc_r, pred_target_r, mispred_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];

   always #5 CLK = ~CLK;

   fetch_bpred #(.BTB_ENTRIES(16), .CTR_BITS(2), .WORD_W(32)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .pc(pc),
      .stall(stall), .flush(flush), .upd_en(upd_en), .upd_pc(upd_pc),
      .upd_taken(upd_taken), .upd_target(upd_target),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .instr_r(instr_r), .npc_r(npc_r), .pred_taken_r(pred_taken_r),
      .pred_target_r(pred_target_r), .mispred_cnt(mispred_cnt)
   );

`ifdef FETCH_BTFN_EN
   localparam bit BTFN = 1'b1;
`else
   localparam bit BTFN = 1'b0;
`endif

   localparam logic [31:0] I_J      = 32'h0800_0100; // J 0x100
   localparam logic [31:0] I_J2     = 32'h0800_0010; // J 0x10
   localparam logic [31:0] I_BEQ_BK = 32'h1000_FFF7; // BEQ off -9 words
   localparam logic [31:0] I_BEQ_FW = 32'h1000_0004; // BEQ off +4 words
   localparam logic [31:0] I_BNE_BK = 32'h1400_FFFE; // BNE off -2 words
   localparam logic [31:0] I_ADDI   = 32'h2001_0005;

   task automatic expect_val(input string tag, input logic [31:0] v);
      sb.push_back('{tag, v});
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic fetch(input logic hv, input logic [31:0] p, input logic [31:0] ins,
                        input logic sv, input logic fv);
      ihit = hv; pc = p; imemload = ins; stall = sv; flush = fv;
   endtask

   task automatic upd(input logic en, input logic [31:0] p, input logic t,
                      input logic [31:0] tgt);
      upd_en = en; upd_pc = p; upd_taken = t; upd_target = tgt;
   endtask

   // One resolution of the BEQ at 0x80 while it is being fetched.
   task automatic upd_step(input string nm, input logic t, input logic [31:0] tgt,
                           input logic [31:0] exp_cnt, input logic exp_pred);
      @(negedge CLK);
      upd(1'b1, 32'h80, t, tgt);
      expect_val({nm, "_cnt"}, exp_cnt);
      expect_val({nm, "_pred"}, {31'b0, exp_pred});
      @(posedge CLK); #1;
      upd(1'b0, 32'h0, 1'b0, 32'h0);
      check(mispred_cnt);
      check({31'b0, pred_taken});
   endtask

   logic [31:0] m;

   initial begin
      nRST = 1'b0;
      fetch(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      upd(1'b0, 32'h0, 1'b0, 32'h0);
      m = BTFN ? 32'd0 : 32'd1;

      // reset state
      #3;
      expect_val("rst_instr_r", 32'h0);       check(instr_r);
      expect_val("rst_npc_r", 32'h0);         check(npc_r);
      expect_val("rst_pred_taken_r", 32'h0);  check({31'b0, pred_taken_r});
      expect_val("rst_pred_target_r", 32'h0); check(pred_target_r);
      expect_val("rst_mispred_cnt", 32'h0);   check(mispred_cnt);
      expect_val("rst_pred_taken", 32'h0);    check({31'b0, pred_taken});

      // J at 0x40
      @(negedge CLK);
      nRST = 1'b1;
      fetch(1'b1, 32'h40, I_J, 1'b0, 1'b0);
      expect_val("j_pred_taken", 32'h1);
      expect_val("j_pred_target", 32'h400);
      #2;
      check({31'b0, pred_taken});
      check(pred_target);
      expect_val("j_npc_r", 32'h44);
      expect_val("j_pred_taken_r", 32'h1);
      expect_val("j_instr_r", I_J);
      expect_val("j_pred_target_r", 32'h400);
      @(posedge CLK); #1;
      check(npc_r); check({31'b0, pred_taken_r}); check(instr_r); check(pred_target_r);

      // cold BEQ at 0x80, resolved taken to 0x60 in the same cycle (no bypass)
      @(negedge CLK);
      fetch(1'b1, 32'h80, I_BEQ_BK, 1'b0, 1'b0);
      upd(1'b1, 32'h80, 1'b1, 32'h60);
      expect_val("cold_pred_taken", {31'b0, BTFN});
      expect_val("cold_pred_target", BTFN ? 32'h60 : 32'h0);
      #2;
      check({31'b0, pred_taken});
      check(pred_target);
      expect_val("alloc_cnt", m);
      expect_val("alloc_pred_taken", 32'h1);
      expect_val("alloc_pred_target", 32'h60);
      @(posedge CLK); #1;
      upd(1'b0, 32'h0, 1'b0, 32'h0);
      check(mispred_cnt); check({31'b0, pred_taken}); check(pred_target);

      // counter walk: 2 ->1 ->0 ->0 ->1 ->2 ->3 ->3 ->2
      upd_step("nt1", 1'b0, 32'h300, m + 1, 1'b0);
      upd_step("nt2", 1'b0, 32'h300, m + 1, 1'b0);
      upd_step("nt_sat", 1'b0, 32'h300, m + 1, 1'b0);
      upd_step("t1", 1'b1, 32'h60, m + 2, 1'b0);
      upd_step("t2", 1'b1, 32'h60, m + 3, 1'b1);
      upd_step("t3", 1'b1, 32'h60, m + 3, 1'b1);
      upd_step("t_sat", 1'b1, 32'h60, m + 3, 1'b1);
      upd_step("nt_from_max", 1'b0, 32'h300, m + 4, 1'b1);
      expect_val("nt_keeps_target", 32'h60);
      check(pred_target);

      // aliasing update at 0xC0, applied while the latch is flushed/stalled
      @(negedge CLK);
      fetch(1'b1, 32'h80, I_BEQ_BK, 1'b1, 1'b1);
      upd(1'b1, 32'hC0, 1'b1, 32'h200);
      expect_val("alias_cnt", m + 5);
      expect_val("alias_pred_taken", {31'b0, BTFN});
      expect_val("alias_pred_target", BTFN ? 32'h60 : 32'h0);
      expect_val("flush_instr_r", 32'h0);
      @(posedge CLK); #1;
      upd(1'b0, 32'h0, 1'b0, 32'h0);
      check(mispred_cnt); check({31'b0, pred_taken}); check(pred_target); check(instr_r);

      // latch control
      @(negedge CLK);
      fetch(1'b1, 32'h100, I_ADDI, 1'b0, 1'b0);
      expect_val("load_instr_r", I_ADDI);
      expect_val("load_npc_r", 32'h104);
      expect_val("load_pred_taken_r", 32'h0);
      @(posedge CLK); #1;
      check(instr_r); check(npc_r); check({31'b0, pred_taken_r});

      @(negedge CLK);
      fetch(1'b1, 32'h200, I_J2, 1'b1, 1'b1);
      expect_val("fs_instr_r", 32'h0);
      expect_val("fs_npc_r", 32'h0);
      expect_val("fs_pred_taken_r", 32'h0);
      expect_val("fs_pred_target_r", 32'h0);
      @(posedge CLK); #1;
      check(instr_r); check(npc_r); check({31'b0, pred_taken_r}); check(pred_target_r);

      @(negedge CLK);
      fetch(1'b1, 32'h100, I_ADDI, 1'b0, 1'b0);
      expect_val("reload_instr_r", I_ADDI);
      @(posedge CLK); #1;
      check(instr_r);

      @(negedge CLK);
      fetch(1'b1, 32'h200, I_J2, 1'b1, 1'b0);
      expect_val("stall_pred_taken", 32'h1);
      expect_val("stall_pred_target", 32'h40);
      #2;
      check({31'b0, pred_taken}); check(pred_target);
      expect_val("stall_instr_r", I_ADDI);
      expect_val("stall_npc_r", 32'h104);
      @(posedge CLK); #1;
      check(instr_r); check(npc_r);

      @(negedge CLK);
      fetch(1'b0, 32'h200, I_J2, 1'b0, 1'b0);
      expect_val("noihit_pred_taken", 32'h0);
      expect_val("noihit_pred_target", 32'h0);
      #2;
      check({31'b0, pred_taken}); check(pred_target);
      expect_val("noihit_instr_r", I_ADDI);
      @(posedge CLK); #1;
      check(instr_r);

      // BNE backward at 0x100, BTB miss (idx 0 holds tag of 0xC0)
      @(negedge CLK);
      fetch(1'b1, 32'h100, I_BNE_BK, 1'b0, 1'b0);
      expect_val("btfn_pred_taken", {31'b0, BTFN});
      expect_val("btfn_pred_target", BTFN ? 32'hFC : 32'h0);
      #2;
      check({31'b0, pred_taken}); check(pred_target);

      // reset mid-operation with a pending update
      @(negedge CLK);
      upd(1'b1, 32'hC0, 1'b1, 32'h200);
      #2;
      nRST = 1'b0;
      #1;
      expect_val("midrst_cnt", 32'h0);     check(mispred_cnt);
      expect_val("midrst_instr_r", 32'h0); check(instr_r);
      expect_val("midrst_npc_r", 32'h0);   check(npc_r);
      @(negedge CLK);
      nRST = 1'b1;
      upd(1'b0, 32'h0, 1'b0, 32'h0);
      fetch(1'b1, 32'hC0, I_BEQ_FW, 1'b0, 1'b0);
      expect_val("postrst_pred_taken", 32'h0);
      #2;
      check({31'b0, pred_taken});
      @(negedge CLK);
      upd(1'b1, 32'hC0, 1'b1, 32'h200);
      expect_val("postrst_cnt", 32'h1);
      expect_val("postrst_pred_taken2", 32'h1);
      expect_val("postrst_pred_target", 32'h200);
      @(posedge CLK); #1;
      upd(1'b0, 32'h0, 1'b0, 32'h0);
      check(mispred_cnt); check({31'b0, pred_taken}); check(pred_target);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
